// File: rtl/ex_mem_pkg.sv
// Shared constants and the pipeline-register action encoding used by ex_mem
// (and later mem_wb).
package ex_mem_pkg;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam int   STALL_EX      = 3;
  localparam int   STALL_MEM     = 4;

  // One-hot so downstream logic can test a single bit per action.
  typedef enum logic [4:0] {
    ACT_RESET   = 5'b00001,
    ACT_FLUSH   = 5'b00010,
    ACT_BUBBLE  = 5'b00100,
    ACT_HOLD    = 5'b01000,
    ACT_ADVANCE = 5'b10000
  } pipe_act_e;

endpackage

// File: rtl/ex_mem_pipe_ctl.sv
// Decodes reset, flush and the two relevant stall bits into one pipeline
// register action, in strict priority order.
module pipe_ctl
  import ex_mem_pkg::*;
(
  input  logic      rst,
  input  logic      flush,
  input  logic      stall_cur,
  input  logic      stall_next,
  output pipe_act_e act
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves act unassigned (no latch).
    act = ACT_ADVANCE;
    if (rst == RST_ENABLE) begin
      act = ACT_RESET;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (stall_cur && !stall_next) begin
      act = ACT_BUBBLE;
    end else if (stall_next) begin
      // A later stage stalled alone never comes from ctrl; freezing is the safe reading.
      act = ACT_HOLD;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register, including the MADD/MSUB accumulation state
// that is fed back to EX across its two-cycle stall.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  pipe_act_e act;

  pipe_ctl u_pipe_ctl (
    .rst        (rst),
    .flush      (flush),
    .stall_cur  (stall[STALL_EX]),
    .stall_next (stall[STALL_MEM]),
    .act        (act)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    unique case (act)
      ACT_RESET, ACT_FLUSH: begin
        mem_wd    <= '0;
        mem_wreg  <= WRITE_DISABLE;
        mem_wdata <= '0;
        mem_hi    <= '0;
        mem_lo    <= '0;
        mem_whilo <= WRITE_DISABLE;
        hilo_o    <= '0;
        cnt_o     <= '0;
      end
      ACT_BUBBLE: begin
        // MEM gets a NOP while EX's half-done accumulation is parked here.
        mem_wd    <= '0;
        mem_wreg  <= WRITE_DISABLE;
        mem_wdata <= '0;
        mem_hi    <= '0;
        mem_lo    <= '0;
        mem_whilo <= WRITE_DISABLE;
        hilo_o    <= hilo_i;
        cnt_o     <= cnt_i;
      end
      ACT_ADVANCE: begin
        mem_wd    <= ex_wd;
        mem_wreg  <= ex_wreg;
        mem_wdata <= ex_wdata;
        mem_hi    <= ex_hi;
        mem_lo    <= ex_lo;
        mem_whilo <= ex_whilo;
        hilo_o    <= '0;
        cnt_o     <= '0;
      end
      default: ; // ACT_HOLD keeps every register
    endcase
  end

endmodule

// File: tb/tb_ex_mem.sv
// Directed test of the EX->MEM pipeline register: reset, advance, MADD bubble,
// hold, flush priority and reset priority.
module tb_ex_mem;
  import ex_mem_pkg::*;

  localparam int W = 5 + 1 + 32 + 32 + 32 + 1 + 64 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] obs;
  assign obs = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi),
    .ex_lo(ex_lo), .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  // ctrl must never stall MEM while EX advances.
  always @(negedge clk) begin
    if (rst === 1'b1 && stall[STALL_EX] === 1'b0 && stall[STALL_MEM] === 1'b1)
      $error("illegal stall pattern %b", stall);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    rst = 1'b0; flush = 1'b0; stall = 6'b0;
    set_ex(5'h1f, 1'b1, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 1'b1);
    hilo_i = '1; cnt_i = 2'b11;
    exp = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_%0d: got %h required %h", i, obs, exp);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_advance();
    logic [W-1:0] exp;
    hilo_i = '0; cnt_i = 2'd0;
    set_ex(5'd7, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    tick();
    exp = {5'd7, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL advance: got %h required %h", obs, exp); end
    // Changing inputs between edges must not reach the outputs.
    set_ex(5'd3, 1'b0, 32'h0BAD_F00D, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
    #3;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL no_comb_path: got %h required %h", obs, exp); end
    tick();
    exp = {5'd3, 1'b0, 32'h0BAD_F00D, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 64'h0, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL advance_next: got %h required %h", obs, exp); end
  endtask

  task automatic test_madd();
    logic [W-1:0] exp;
    set_ex(5'd9, 1'b1, 32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222, 1'b1);
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    tick();
    exp = {5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_0000_0002, 2'd1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL madd_bubble: got %h required %h", obs, exp); end
    // ADVANCE must zero the feedback even if EX still drives something.
    stall = 6'b0; hilo_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd1;
    tick();
    exp = {5'd9, 1'b1, 32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222, 1'b1, 64'h0, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL madd_advance: got %h required %h", obs, exp); end
  endtask

  task automatic test_hold();
    logic [W-1:0] exp;
    stall = 6'b0; hilo_i = '0; cnt_i = 2'd0;
    set_ex(5'd12, 1'b1, 32'h1234_5678, 32'hCAFE_0000, 32'h0000_BABE, 1'b0);
    tick();
    exp = {5'd12, 1'b1, 32'h1234_5678, 32'hCAFE_0000, 32'h0000_BABE, 1'b0, 64'h0, 2'd0};
    stall = 6'b011111;
    set_ex(5'd30, 1'b0, 32'h0, 32'h5555_5555, 32'h6666_6666, 1'b1);
    hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL hold_%0d: got %h required %h", i, obs, exp); end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] exp;
    stall = 6'b001111; hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'd1;
    tick();
    exp = {5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0000_0003_0000_0004, 2'd1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_setup: got %h required %h", obs, exp); end
    flush = 1'b1;
    tick();
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_wins: got %h required %h", obs, exp); end
    flush = 1'b0;
  endtask

  task automatic test_reset_priority();
    logic [W-1:0] exp;
    stall = 6'b0; hilo_i = '0; cnt_i = 2'd0;
    set_ex(5'd21, 1'b1, 32'h8000_0001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
    tick();
    exp = {5'd21, 1'b1, 32'h8000_0001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 64'h0, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rstprio_setup: got %h required %h", obs, exp); end
    rst = 1'b0; flush = 1'b1;
    tick();
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rstprio_reset: got %h required %h", obs, exp); end
    rst = 1'b1; flush = 1'b0;
    tick();
    exp = {5'd21, 1'b1, 32'h8000_0001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 64'h0, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rstprio_release: got %h required %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    stall = 6'b0;
    for (int i = 1; i <= 3; i++) begin
      set_ex(5'(i), i[0], 32'h1000_0000 * i, 32'(i), 32'(i + 1), ~i[0]);
      tick();
      exp = {5'(i), i[0], 32'h1000_0000 * i, 32'(i), 32'(i + 1), ~i[0], 64'h0, 2'd0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b_%0d: got %h required %h", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_madd();
    test_hold();
    test_flush();
    test_reset_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
